// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs LANES entries little-endian into one valid/ready word; flush emits a partial word.
// Latency: last pop at cycle N -> out_valid at N+2. Backpressure: HOLD freezes the word and stops popping.
// Optional idle auto-flush is compiled in with `define FIFO_PACKER_TIMEOUT_EN.
module fifo_word_packer #(
    parameter int DATA_W         = 8,
    parameter int LANES          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fifo_empty,
    input  logic [DATA_W-1:0]            fifo_data,
    output logic                         fifo_rd_en,
    input  logic                         flush,
    output logic [DATA_W*LANES-1:0]      out_data,
    output logic [LANES-1:0]             out_keep,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(LANES+1)-1:0]   fill_cnt
);

    localparam int CW = $clog2(LANES + 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CW-1:0]           fill_q, fill_d;
    logic                    pend_q, pend_d;
    logic [DATA_W*LANES-1:0] data_q, data_d;
    logic [LANES-1:0]        keep_q, keep_d;
    logic                    valid_q, valid_d;

    logic                    flush_evt;
    logic                    flush_latched;
    logic                    timeout_hit;
    logic [CW:0]             occupancy;
    logic [CW-1:0]           fill_inc;

    // A flush seen while a byte is in flight is resolved on the edge that captures it,
    // so the latch only needs to exist as a combinational pop blocker.
    assign flush_evt     = flush | timeout_hit;
    assign flush_latched = flush_evt & pend_q;

    assign occupancy = {1'b0, fill_q} + {{CW{1'b0}}, pend_q};
    assign fill_inc  = fill_q + CW'(1);

    assign fifo_rd_en = (state_q == ST_FILL) && !fifo_empty && !flush_evt && !flush_latched
                        && (occupancy < (CW+1)'(LANES));

`ifdef FIFO_PACKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_q, idle_d;
    logic          idle_counting;

    assign idle_counting = (state_q == ST_FILL) && (fill_q != '0) && fifo_empty && !pend_q;
    assign timeout_hit   = idle_counting && (idle_q == TW'(TIMEOUT_CYCLES - 1));
    assign idle_d        = (idle_counting && !timeout_hit) ? idle_q + TW'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        pend_d  = fifo_rd_en;

        if (state_q == ST_FILL) begin
            if (pend_q) begin
                for (int i = 0; i < LANES; i++) begin
                    if (fill_q == CW'(i)) begin
                        data_d[i*DATA_W +: DATA_W] = fifo_data;
                        keep_d[i]                  = 1'b1;
                    end
                end
                fill_d = fill_inc;
                if ((fill_inc == CW'(LANES)) || flush_evt) begin
                    state_d = ST_HOLD;
                    valid_d = 1'b1;
                end
            end else if (flush_evt && (fill_q != '0)) begin
                state_d = ST_HOLD;
                valid_d = 1'b1;
            end
        end else begin
            if (out_ready) begin
                state_d = ST_FILL;
                valid_d = 1'b0;
                fill_d  = '0;
                keep_d  = '0;
                data_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_valid = valid_q;
    assign fill_cnt  = fill_q;

endmodule
